pattern_tx: RTL

Serial pattern transmitter: the source end of the team's 1010 sequence-detection link. It accepts a parallel word over a valid/ready handshake and drives a serial bit stream: a fixed `1010` preamble, then the payload MSB-first, then an optional parity bit. Each bit is held for a programmable number of clocks. The block drives the detector's single-bit serial input `i` and also serves as its loopback stimulus source.

---
 rtl/pattern_pkg.sv | 20 ++
 rtl/pattern_tx_bit_timer.sv | 29 ++
 rtl/pattern_tx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the 1010 pattern link: FSM state codes (3-bit, common with the
// detector's pst), the default preamble and the parity helper.
package pattern_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3
  } state_e;

  localparam logic [3:0] PREAMBLE_DEFAULT = 4'b1010;

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/pattern_tx_bit_timer.sv
// bit_timer: counts clocks within one transmitted bit-time and strobes on the last one.
module bit_timer #(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic wrap
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-time counter: 0..BIT_DIV-1, held at zero while the transmitter is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr || (cnt_r == CNT_MAX)) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign wrap = (cnt_r == CNT_MAX);

endmodule

// File: rtl/pattern_tx.sv
// pattern_tx: sends preamble + MSB-first payload (+ even parity when PATTERN_TX_PARITY_EN
// is defined) on a single serial line, each bit held for BIT_DIV clocks.
module pattern_tx
  import pattern_pkg::*;
#(
  parameter int                 DATA_W   = 8,
  parameter int                 PRE_LEN  = 4,
  parameter logic [PRE_LEN-1:0] PREAMBLE = PRE_LEN'(PREAMBLE_DEFAULT),
  parameter int                 BIT_DIV  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              o,
  output logic              o_valid,
  output logic              busy,
  output logic [2:0]        pst
);

  localparam int IDX_MAX = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PRE_LEN - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);

  state_e             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [DATA_W-1:0]  shift_r;
  logic [DATA_W-1:0]  shift_nx_s;
  logic [PRE_LEN-1:0] pre_nx_s;
  logic               wrap_s;
`ifdef PATTERN_TX_PARITY_EN
  logic               par_r;
`endif

  // o is registered, so each branch loads the bit for the coming bit-time.
  assign shift_nx_s = shift_r << 1'b1;
  assign pre_nx_s   = PREAMBLE << (idx_r + 1'b1);
  assign pst        = state_r;

  bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_r == IDLE),
    .wrap (wrap_s)
  );

  // Frame FSM with registered serial and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      shift_r   <= {DATA_W{1'b0}};
`ifdef PATTERN_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
      o         <= 1'b0;
      o_valid   <= 1'b0;
      busy      <= 1'b0;
      din_ready <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (din_valid && din_ready) begin
            state_r   <= PRE;
            idx_r     <= {IDX_W{1'b0}};
            shift_r   <= din;
`ifdef PATTERN_TX_PARITY_EN
            par_r     <= even_parity(32'(din));
`endif
            o         <= PREAMBLE[PRE_LEN-1];
            o_valid   <= 1'b1;
            busy      <= 1'b1;
            din_ready <= 1'b0;
          end
        end
        PRE: begin
          if (wrap_s) begin
            if (idx_r == PRE_LAST) begin
              state_r <= DATA;
              idx_r   <= {IDX_W{1'b0}};
              o       <= shift_r[DATA_W-1];
            end else begin
              idx_r   <= idx_r + 1'b1;
              o       <= pre_nx_s[PRE_LEN-1];
            end
          end
        end
        DATA: begin
          if (wrap_s) begin
            if (idx_r == DATA_LAST) begin
              idx_r     <= {IDX_W{1'b0}};
`ifdef PATTERN_TX_PARITY_EN
              state_r   <= PAR;
              o         <= par_r;
`else
              state_r   <= IDLE;
              o         <= 1'b0;
              o_valid   <= 1'b0;
              busy      <= 1'b0;
              din_ready <= 1'b1;
`endif
            end else begin
              idx_r   <= idx_r + 1'b1;
              shift_r <= shift_nx_s;
              o       <= shift_nx_s[DATA_W-1];
            end
          end
        end
`ifdef PATTERN_TX_PARITY_EN
        PAR: begin
          if (wrap_s) begin
            state_r   <= IDLE;
            o         <= 1'b0;
            o_valid   <= 1'b0;
            busy      <= 1'b0;
            din_ready <= 1'b1;
          end
        end
`endif
        default: begin
          state_r   <= IDLE;
          idx_r     <= {IDX_W{1'b0}};
          o         <= 1'b0;
          o_valid   <= 1'b0;
          busy      <= 1'b0;
          din_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
